dist_acc_feeder: RTL and testbench

- Upstream neighbour of the misc stage (nonlinear + k-sort). Accumulates per-element partial results, e.g. squared differences from the multiplier/adder stages, into one scalar per sample. Each scalar could be a distance or a dot product.
- Streams each (value, sample index) pair into the misc stage's in/index inputs.
- Generates the one-cycle clear_reg pulse that resets the k-sort register bank at the start of every query.

---
 rtl/dist_acc_feeder_if.sv | 35 +++
 rtl/dist_acc_feeder.sv | 154 +++++++++++++++
 tb/tb_dist_acc_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_acc_feeder_if.sv
// Handshake/bus bundle between the query controller, the partial-term producer
// and the misc stage (nonlinear + k-sort).
//   start/vec_len/num_samples : query launch and lengths
//   in_valid/in_ready/in_data : partial-term stream into the accumulator
//   out_valid/out_val/out_index : one accumulated scalar per sample to misc
//   clear_reg/busy/done       : misc register-bank clear and query status
interface dist_acc_feeder_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] vec_len;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_val;
    logic [WIDTH-1:0] out_index;
    logic             clear_reg;
    logic             busy;
    logic             done;

    // Driver side: launches queries and supplies partial terms.
    modport master (
        output start, vec_len, num_samples, in_valid, in_data,
        input  in_ready, out_valid, out_val, out_index, clear_reg, busy, done
    );

    // Feeder side.
    modport slave (
        input  start, vec_len, num_samples, in_valid, in_data,
        output in_ready, out_valid, out_val, out_index, clear_reg, busy, done
    );
endinterface

// File: rtl/dist_acc_feeder.sv
// Accumulates vec_len signed partial terms per sample into one scalar and
// streams (value, sample index) pairs to the misc stage, bracketing each query
// with a one-cycle clear_reg pulse at the start and a done pulse at the end.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : dist_acc_feeder_if slave modport (all handshake/data signals)
module dist_acc_feeder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dist_acc_feeder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_e;

    state_e           state_q,       state_d;
    logic [WIDTH-1:0] acc_q,         acc_d;
    logic [WIDTH-1:0] out_val_q,     out_val_d;
    logic [WIDTH-1:0] out_index_q,   out_index_d;
    logic [CNT_W-1:0] elem_cnt_q,    elem_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q,  sample_cnt_d;
    logic [CNT_W-1:0] vec_len_q,     vec_len_d;
    logic [CNT_W-1:0] num_samples_q, num_samples_d;

    logic in_ready_q,  in_ready_d;
    logic out_valid_q, out_valid_d;
    logic clear_reg_q, clear_reg_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;

    logic             xfer_c;
    logic [WIDTH-1:0] sum_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            out_val_q     <= '0;
            out_index_q   <= '0;
            elem_cnt_q    <= '0;
            sample_cnt_q  <= '0;
            vec_len_q     <= '0;
            num_samples_q <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            clear_reg_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            out_val_q     <= out_val_d;
            out_index_q   <= out_index_d;
            elem_cnt_q    <= elem_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            vec_len_q     <= vec_len_d;
            num_samples_q <= num_samples_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            clear_reg_q   <= clear_reg_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        out_val_d     = out_val_q;
        out_index_d   = out_index_q;
        elem_cnt_d    = elem_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        vec_len_d     = vec_len_q;
        num_samples_d = num_samples_q;

        // in_ready_q is only ever high while in ACCUM.
        xfer_c = bus.in_valid & in_ready_q;
        // First element of a sample overwrites the accumulator instead of adding.
        sum_c  = (elem_cnt_q == '0) ? bus.in_data : WIDTH'(acc_q + bus.in_data);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    vec_len_d     = bus.vec_len;
                    num_samples_d = bus.num_samples;
                    if ((bus.vec_len != '0) && (bus.num_samples != '0)) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                elem_cnt_d   = '0;
                sample_cnt_d = '0;
                acc_d        = '0;
                state_d      = S_ACCUM;
            end
            S_ACCUM: begin
                if (xfer_c) begin
                    acc_d = sum_c;
                    if (elem_cnt_q == CNT_W'(vec_len_q - CNT_W'(1))) begin
                        out_val_d   = sum_c;
                        out_index_d = WIDTH'(sample_cnt_q);
                        elem_cnt_d  = '0;
                        state_d     = S_EMIT;
                    end else begin
                        elem_cnt_d = CNT_W'(elem_cnt_q + CNT_W'(1));
                    end
                end
            end
            S_EMIT: begin
                if (sample_cnt_q == CNT_W'(num_samples_q - CNT_W'(1))) begin
                    state_d = S_DONE;
                end else begin
                    sample_cnt_d = CNT_W'(sample_cnt_q + CNT_W'(1));
                    state_d      = S_ACCUM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they register in
        // step with the state they describe.
        in_ready_d  = (state_d == S_ACCUM);
        out_valid_d = (state_d == S_EMIT);
        clear_reg_d = (state_d == S_CLEAR);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_index = out_index_q;
    assign bus.clear_reg = clear_reg_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dist_acc_feeder.sv
// Bench for dist_acc_feeder: randomized partial-term streams checked against a
// reference that sums each group of vec_len terms with 32-bit wrap-around and
// derives expected pulse timing from the observed accept cycles.
module tb_dist_acc_feeder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dist_acc_feeder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    dist_acc_feeder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int asserts = 0;
    int fails   = 0;

    // Stimulus and reference expectations.
    logic [31:0] stim_q[$];
    logic [31:0] exp_val[$];

    // Observations collected while a query runs.
    logic [31:0] ov_q[$];
    logic [31:0] oi_q[$];
    int          oc_q[$];
    int          acc_cyc[$];
    int          clr_cyc[$];
    int          done_cyc[$];
    int          overlap_cnt;
    int          start_cyc;
    bit          timed_out;

    // Reference: each sample is the plain wrapped sum of its vec_len terms.
    function automatic void build_expect(input int vl, input int ns);
        exp_val.delete();
        for (int s = 0; s < ns; s++) begin
            logic [31:0] sum;
            sum = 32'd0;
            for (int e = 0; e < vl; e++) sum = sum + stim_q[s*vl + e];
            exp_val.push_back(sum);
        end
    endfunction

    function automatic void fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back($urandom);
    endfunction

    // Runs one query from stim_q and records what the DUT emitted.
    // mode: 0 full rate, 1 alternate bubbles, 2 random in_valid.
    // poke: raise start again (with different lengths) while busy.
    task automatic drive_query(input int vl, input int ns, input int mode, input bit poke);
        int  k;
        int  n;
        bit  finished;
        ov_q.delete(); oi_q.delete(); oc_q.delete();
        acc_cyc.delete(); clr_cyc.delete(); done_cyc.delete();
        overlap_cnt = 0;
        k = 0; n = 0; finished = 1'b0;
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.vec_len     = 16'(vl);
        bus.num_samples = 16'(ns);
        bus.in_valid    = 1'b0;
        start_cyc       = cyc;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        // Lengths are latched on start, so scramble them afterwards.
        bus.vec_len     = 16'($urandom_range(0, 9));
        bus.num_samples = 16'($urandom_range(0, 9));
        while (!finished && n < 3000) begin
            case (mode)
                1:       bus.in_valid = (k < stim_q.size()) && (n % 2 == 0);
                2:       bus.in_valid = (k < stim_q.size()) && ($urandom_range(0, 1) == 1);
                default: bus.in_valid = (k < stim_q.size());
            endcase
            bus.in_data = bus.in_valid ? stim_q[k] : $urandom;
            bus.start   = poke && (n == 3);
            if (bus.start) begin
                bus.vec_len     = 16'd1;
                bus.num_samples = 16'd5;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                k++;
            end
            if (bus.out_valid) begin
                ov_q.push_back(bus.out_val);
                oi_q.push_back(bus.out_index);
                oc_q.push_back(cyc);
            end
            if (bus.clear_reg) clr_cyc.push_back(cyc);
            if (bus.done) begin
                done_cyc.push_back(cyc);
                finished = 1'b1;
            end
            if ((bus.out_valid && (bus.in_ready || bus.clear_reg || bus.done)) ||
                (bus.clear_reg && bus.done)) overlap_cnt++;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        timed_out    = !finished;
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.vec_len     = '0;
        bus.num_samples = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        #12;
        asserts++;
        if ({bus.out_valid, bus.clear_reg, bus.in_ready, bus.busy, bus.done} !== 5'b0 ||
            bus.out_val !== 32'd0 || bus.out_index !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: got flags=%b val=%h idx=%h, need all 0",
                     {bus.out_valid, bus.clear_reg, bus.in_ready, bus.busy, bus.done},
                     bus.out_val, bus.out_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        build_expect(3, 2);
        drive_query(3, 2, 0, 1'b0);
        asserts++;
        if (timed_out) begin fails++; $display("FAIL basic_timeout: no done within budget, need done"); end
        asserts++;
        if (clr_cyc.size() != 1 || clr_cyc[0] != start_cyc + 1) begin
            fails++;
            $display("FAIL basic_clear: %0d pulses first@%0d, need 1 @%0d",
                     clr_cyc.size(), (clr_cyc.size() > 0) ? clr_cyc[0] : -1, start_cyc + 1);
        end
        asserts++;
        if (ov_q.size() != 2) begin fails++; $display("FAIL basic_count: got %0d emits, need 2", ov_q.size()); end
        for (int i = 0; i < 2 && i < ov_q.size(); i++) begin
            asserts++;
            if (ov_q[i] !== exp_val[i] || oi_q[i] !== 32'(i)) begin
                fails++;
                $display("FAIL basic_emit%0d: got (%0d,%0d), need (%0d,%0d)", i, ov_q[i], oi_q[i], exp_val[i], i);
            end
            asserts++;
            if ((3*i + 2) >= acc_cyc.size() || oc_q[i] != acc_cyc[3*i + 2] + 1) begin
                fails++;
                $display("FAIL basic_latency%0d: out_valid@%0d, need 1 cycle after last beat", i, oc_q[i]);
            end
        end
        asserts++;
        if (done_cyc.size() != 1 || oc_q.size() != 2 || done_cyc[0] != oc_q[1] + 1) begin
            fails++;
            $display("FAIL basic_done: %0d done pulses, need 1 right after second out_valid", done_cyc.size());
        end
        asserts++;
        if (overlap_cnt != 0) begin fails++; $display("FAIL basic_overlap: got %0d overlaps, need 0", overlap_cnt); end
        @(negedge clk);
        asserts++;
        if (bus.busy !== 1'b0 || bus.out_val !== 32'd15 || bus.out_index !== 32'd1) begin
            fails++;
            $display("FAIL basic_idle_hold: busy=%b val=%0d idx=%0d, need busy=0 val=15 idx=1",
                     bus.busy, bus.out_val, bus.out_index);
        end
    endtask

    task automatic test_bubbles;
        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        build_expect(3, 2);
        drive_query(3, 2, 1, 1'b0);
        asserts++;
        if (timed_out || ov_q.size() != 2) begin
            fails++;
            $display("FAIL bubbles_count: got %0d emits (timeout=%0b), need 2", ov_q.size(), timed_out);
        end
        for (int i = 0; i < 2 && i < ov_q.size(); i++) begin
            asserts++;
            if (ov_q[i] !== exp_val[i] || oi_q[i] !== 32'(i) ||
                (3*i + 2) >= acc_cyc.size() || oc_q[i] != acc_cyc[3*i + 2] + 1) begin
                fails++;
                $display("FAIL bubbles_emit%0d: got (%0d,%0d)@%0d, need (%0d,%0d) after last beat",
                         i, ov_q[i], oi_q[i], oc_q[i], exp_val[i], i);
            end
        end
        asserts++;
        if (overlap_cnt != 0) begin fails++; $display("FAIL bubbles_ready_in_emit: got %0d, need 0", overlap_cnt); end
    endtask

    task automatic test_wrap_sign;
        stim_q = '{32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFB, 32'h0000_0003};
        drive_query(2, 2, 0, 1'b0);
        asserts++;
        if (ov_q.size() != 2 || ov_q[0] !== 32'h8000_0000 || ov_q[1] !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL wrap_sign: got %0d emits first=%h, need 80000000 then fffffffe",
                     ov_q.size(), (ov_q.size() > 0) ? ov_q[0] : 32'hx);
        end
    endtask

    task automatic test_degenerate;
        stim_q.delete();
        drive_query(4, 0, 0, 1'b0);
        asserts++;
        if (timed_out || done_cyc.size() != 1 || done_cyc[0] != start_cyc + 1 ||
            clr_cyc.size() != 0 || ov_q.size() != 0) begin
            fails++;
            $display("FAIL zero_samples: done=%0d clear=%0d emits=%0d, need done next cycle, no clear, no emit",
                     done_cyc.size(), clr_cyc.size(), ov_q.size());
        end
        stim_q = '{32'd7, 32'd8, 32'd9};
        drive_query(1, 3, 0, 1'b0);
        asserts++;
        if (ov_q.size() != 3) begin fails++; $display("FAIL vl1_count: got %0d emits, need 3", ov_q.size()); end
        for (int i = 0; i < 3 && i < ov_q.size(); i++) begin
            asserts++;
            if (ov_q[i] !== 32'(7 + i) || oi_q[i] !== 32'(i)) begin
                fails++;
                $display("FAIL vl1_emit%0d: got (%0d,%0d), need (%0d,%0d)", i, ov_q[i], oi_q[i], 7 + i, i);
            end
        end
    endtask

    task automatic test_ignored_start;
        fill_random(8);
        build_expect(4, 2);
        drive_query(4, 2, 0, 1'b1);
        asserts++;
        if (ov_q.size() != 2 || clr_cyc.size() != 1 || done_cyc.size() != 1) begin
            fails++;
            $display("FAIL busy_start_counts: emits=%0d clears=%0d dones=%0d, need 2/1/1",
                     ov_q.size(), clr_cyc.size(), done_cyc.size());
        end
        for (int i = 0; i < 2 && i < ov_q.size(); i++) begin
            asserts++;
            if (ov_q[i] !== exp_val[i] || oi_q[i] !== 32'(i)) begin
                fails++;
                $display("FAIL busy_start_emit%0d: got (%h,%0d), need (%h,%0d)", i, ov_q[i], oi_q[i], exp_val[i], i);
            end
        end
    endtask

    task automatic test_random;
        for (int q = 0; q < 5; q++) begin
            int vl;
            int ns;
            vl = $urandom_range(1, 5);
            ns = $urandom_range(1, 4);
            fill_random(vl * ns);
            build_expect(vl, ns);
            drive_query(vl, ns, $urandom_range(0, 2), 1'b0);
            asserts++;
            if (timed_out || ov_q.size() != ns || overlap_cnt != 0) begin
                fails++;
                $display("FAIL rand%0d_shape: emits=%0d need %0d, timeout=%0b overlaps=%0d",
                         q, ov_q.size(), ns, timed_out, overlap_cnt);
            end
            for (int i = 0; i < ns && i < ov_q.size(); i++) begin
                asserts++;
                if (ov_q[i] !== exp_val[i] || oi_q[i] !== 32'(i) ||
                    ((i+1)*vl - 1) >= acc_cyc.size() || oc_q[i] != acc_cyc[(i+1)*vl - 1] + 1) begin
                    fails++;
                    $display("FAIL rand%0d_emit%0d: got (%h,%0d)@%0d, need (%h,%0d)",
                             q, i, ov_q[i], oi_q[i], oc_q[i], exp_val[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int n;
        bit saw_done;
        fill_random(12);
        k = 0; n = 0; saw_done = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.vec_len = 16'd4; bus.num_samples = 16'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // Feed until two beats of the second sample have been accepted.
        while (k < 6 && n < 200) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[k];
            @(negedge clk);
            if (bus.in_ready) k++;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        asserts++;
        if (k != 6 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_setup: accepted %0d busy=%b, need 6 accepted and busy", k, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        asserts++;
        if ({bus.out_valid, bus.clear_reg, bus.in_ready, bus.busy, bus.done} !== 5'b0 ||
            bus.out_val !== 32'd0 || bus.out_index !== 32'd0) begin
            fails++;
            $display("FAIL midreset_outputs: flags=%b val=%h idx=%h, need all 0",
                     {bus.out_valid, bus.clear_reg, bus.in_ready, bus.busy, bus.done},
                     bus.out_val, bus.out_index);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        asserts++;
        if (saw_done) begin fails++; $display("FAIL midreset_done: got done pulse, need none"); end
        fill_random(4);
        build_expect(2, 2);
        drive_query(2, 2, 0, 1'b0);
        asserts++;
        if (clr_cyc.size() != 1 || ov_q.size() != 2) begin
            fails++;
            $display("FAIL postreset_shape: clears=%0d emits=%0d, need 1 and 2", clr_cyc.size(), ov_q.size());
        end
        for (int i = 0; i < 2 && i < ov_q.size(); i++) begin
            asserts++;
            if (ov_q[i] !== exp_val[i] || oi_q[i] !== 32'(i)) begin
                fails++;
                $display("FAIL postreset_emit%0d: got (%h,%0d), need (%h,%0d)", i, ov_q[i], oi_q[i], exp_val[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_wrap_sign();
        test_degenerate();
        test_ignored_start();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
